// File: rtl/ex_muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer beside the EX-stage ALU.
// Works on operand magnitudes, one radix-2 step per cycle, and sign-corrects the final result.
module ex_muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_EX,
  input  logic [6:0]      opcode_EX,
  input  logic [2:0]      funct3_EX,
  input  logic [6:0]      funct7_EX,
  input  logic [XLEN-1:0] reg_data1_EX,
  input  logic [XLEN-1:0] reg_data2_EX,
  input  logic [4:0]      rd_EX,
  input  logic            flush_EX,
  output logic            stall_EX,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              negQ_q, negQ_d;
  logic              negA_q, negA_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rdOut_q, rdOut_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            mop;
  logic            isDivIn;
  logic            s1Signed, s2Signed;
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            divZero, divOvf, special;
  logic [XLEN-1:0] specRes;

  // Decode and operand preparation for the instruction currently in EX.
  always_comb begin
    mop      = valid_EX & (opcode_EX == OPC_OP) & (funct7_EX == F7_MULDIV) & ~flush_EX;
    isDivIn  = funct3_EX[2];
    s1Signed = (funct3_EX != 3'd3) & (funct3_EX != 3'd5) & (funct3_EX != 3'd7);
    s2Signed = s1Signed & (funct3_EX != 3'd2);
    neg1     = s1Signed & reg_data1_EX[XLEN-1];
    neg2     = s2Signed & reg_data2_EX[XLEN-1];
    mag1     = neg1 ? -reg_data1_EX : reg_data1_EX;
    mag2     = neg2 ? -reg_data2_EX : reg_data2_EX;
    divZero  = (reg_data2_EX == '0);
    divOvf   = ((funct3_EX == 3'd4) | (funct3_EX == 3'd6)) &
               (reg_data1_EX == {1'b1, {(XLEN-1){1'b0}}}) & (reg_data2_EX == '1);
    special  = isDivIn & (divZero | divOvf);
    if (divZero) specRes = funct3_EX[1] ? reg_data1_EX : '1;
    else         specRes = funct3_EX[1] ? '0 : reg_data1_EX;
  end

  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN:0]     divShift, divTrial;
  logic [2*XLEN-1:0] divNext;
  logic [2*XLEN-1:0] stepAcc;
  logic [XLEN-1:0]   stepQuo, stepRem;
  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0]   quoSigned, remSigned;
  logic [XLEN-1:0]   finalRes;

  // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mulNext  = acc_q[0] ? {mulSum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    divShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    divTrial = divShift - {1'b0, opnd_q};
    divNext  = divTrial[XLEN] ? {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    stepAcc  = f3_q[2] ? divNext : mulNext;
    stepQuo  = stepAcc[XLEN-1:0];
    stepRem  = stepAcc[2*XLEN-1:XLEN];

    prodSigned = negQ_q ? -stepAcc : stepAcc;
    quoSigned  = negQ_q ? -stepQuo : stepQuo;
    remSigned  = negA_q ? -stepRem : stepRem;
    if (f3_q[2])               finalRes = f3_q[1] ? remSigned : quoSigned;
    else if (f3_q[1:0] == 2'b00) finalRes = prodSigned[XLEN-1:0];
    else                       finalRes = prodSigned[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush returns to IDLE from any state without touching the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    f3_d    = f3_q;
    negQ_d  = negQ_q;
    negA_d  = negA_q;
    rd_d    = rd_q;
    rdOut_d = rdOut_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (mop) begin
          if (special) begin
            res_d   = specRes;
            rdOut_d = rd_EX;
            state_d = DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, isDivIn ? mag1 : mag2};
            opnd_d  = isDivIn ? mag2 : mag1;
            f3_d    = funct3_EX;
            negQ_d  = neg1 ^ neg2;
            negA_d  = neg1;
            rd_d    = rd_EX;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_EX) begin
          state_d = IDLE;
        end else begin
          acc_d = stepAcc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            res_d   = finalRes;
            rdOut_d = rd_q;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      f3_q    <= '0;
      negQ_q  <= 1'b0;
      negA_q  <= 1'b0;
      rd_q    <= '0;
      rdOut_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      f3_q    <= f3_d;
      negQ_q  <= negQ_d;
      negA_q  <= negA_d;
      rd_q    <= rd_d;
      rdOut_q <= rdOut_d;
      res_q   <= res_d;
    end
  end

  // Stall drops in DONE so the finished op leaves EX and is never re-accepted.
  assign stall_EX     = reset & ~flush_EX & ((mop & (state_q == IDLE)) | (state_q == CALC));
  assign busy         = reset & (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = res_q;
  assign rd_out       = rdOut_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: arithmetic/timing model plus directed vectors.
module tb_ex_muldiv_seq;

  localparam int XLEN = 64;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic valid_EX = 1'b0;
  logic [6:0] opcode_EX = '0;
  logic [2:0] funct3_EX = '0;
  logic [6:0] funct7_EX = '0;
  logic [63:0] reg_data1_EX = '0;
  logic [63:0] reg_data2_EX = '0;
  logic [4:0] rd_EX = '0;
  logic flush_EX = 1'b0;
  logic stall_EX, busy, result_valid;
  logic [63:0] result;
  logic [4:0] rd_out;

  int checks = 0;
  int errors = 0;

  ex_muldiv_seq dut (
    .clk(clk), .reset(reset), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
    .funct3_EX(funct3_EX), .funct7_EX(funct7_EX), .reg_data1_EX(reg_data1_EX),
    .reg_data2_EX(reg_data2_EX), .rd_EX(rd_EX), .flush_EX(flush_EX),
    .stall_EX(stall_EX), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] modelResult(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] b);
    logic signed [127:0] x, y, p;
    longint sa, sb;
    sa = a;
    sb = b;
    x = '0;
    y = '0;
    case (f3)
      3'd0: return a * b;
      3'd1: begin x = {{64{a[63]}}, a}; y = {{64{b[63]}}, b}; end
      3'd2: begin x = {{64{a[63]}}, a}; y = {64'b0, b}; end
      3'd3: begin x = {64'b0, a}; y = {64'b0, b}; end
      3'd4: begin
        if (b == 0) return ONES;
        if (a == MIN && b == ONES) return a;
        return 64'(sa / sb);
      end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == ONES) return 64'd0;
        return 64'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
    p = x * y;
    return p[127:64];
  endfunction

  function automatic bit modelSpecial(input logic [2:0] f3, input logic [63:0] a,
                                      input logic [63:0] b);
    return f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == MIN && b == ONES));
  endfunction

  // Model: count of iteration cycles left, and a flag for the cycle the result is presented.
  int          mLeft = 0;
  bit          mPulse = 0;
  bit          modelLive = 0;
  logic [63:0] mRes = '0, pendRes = '0;
  logic [4:0]  mRd = '0, pendRd = '0;
  logic        mopNow, expStall, expBusy;

  always @(posedge clk) begin
    modelLive = 1;
    mopNow = valid_EX && opcode_EX == OPC_OP && funct7_EX == 7'b0000001 && !flush_EX;
    if (!reset) begin
      mLeft = 0; mPulse = 0; mRes = '0; mRd = '0;
    end else if (flush_EX) begin
      mLeft = 0; mPulse = 0;
    end else if (mPulse) begin
      mPulse = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        mPulse = 1; mRes = pendRes; mRd = pendRd;
      end
    end else if (mopNow) begin
      pendRes = modelResult(funct3_EX, reg_data1_EX, reg_data2_EX);
      pendRd  = rd_EX;
      if (modelSpecial(funct3_EX, reg_data1_EX, reg_data2_EX)) begin
        mPulse = 1; mRes = pendRes; mRd = pendRd;
      end else begin
        mLeft = XLEN;
      end
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      mopNow   = valid_EX && opcode_EX == OPC_OP && funct7_EX == 7'b0000001 && !flush_EX;
      expStall = reset && !flush_EX && ((mopNow && mLeft == 0 && !mPulse) || mLeft > 0);
      expBusy  = reset && (mLeft > 0 || mPulse);
      checkOutput("cycle stall_EX", {63'b0, stall_EX}, {63'b0, expStall});
      checkOutput("cycle busy", {63'b0, busy}, {63'b0, expBusy});
      checkOutput("cycle result_valid", {63'b0, result_valid}, {63'b0, mPulse});
      if (mPulse) begin
        checkOutput("cycle result", result, mRes);
        checkOutput("cycle rd_out", {59'b0, rd_out}, {59'b0, mRd});
      end
    end
  end

  task automatic driveOp(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rdv);
    @(posedge clk);
    #1;
    valid_EX = 1'b1; opcode_EX = OPC_OP; funct7_EX = 7'b0000001; funct3_EX = f3;
    reg_data1_EX = a; reg_data2_EX = b; rd_EX = rdv; flush_EX = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rdv,
                               input logic [63:0] expLit, input int expStall);
    int n = 0;
    bit done = 0;
    driveOp(f3, a, b, rdv);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (stall_EX) n++;
      else done = 1;
    end
    checkOutput({name, " stall cycles"}, 64'(n), 64'(expStall));
    checkOutput({name, " result_valid"}, {63'b0, result_valid}, 64'd1);
    checkOutput({name, " result"}, result, expLit);
    checkOutput({name, " rd_out"}, {59'b0, rd_out}, {59'b0, rdv});
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk);
    #1;
    valid_EX = 1'b0; flush_EX = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog expired before end of stimulus");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    $display("[TB] start");
    valid_EX = 1'b1; opcode_EX = OPC_OP; funct7_EX = 7'b0000001; funct3_EX = 3'd0;
    reg_data1_EX = 64'd5; reg_data2_EX = 64'd5; rd_EX = 5'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset stall_EX", {63'b0, stall_EX}, 64'd0);
    checkOutput("reset busy", {63'b0, busy}, 64'd0);
    checkOutput("reset result_valid", {63'b0, result_valid}, 64'd0);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset rd_out", {59'b0, rd_out}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1; valid_EX = 1'b0;
    idleCycles(2);

    applyStimulus("MUL 3*-5", 3'd0, 64'd3, -64'sd5, 5'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    applyStimulus("MULHU ones", 3'd3, ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    applyStimulus("MULH ones", 3'd1, ONES, ONES, 5'd7, 64'd0, 65);
    applyStimulus("MULH -3*5", 3'd1, -64'sd3, 64'd5, 5'd8, ONES, 65);
    applyStimulus("MULHSU -1*2", 3'd2, ONES, 64'd2, 5'd9, ONES, 65);
    applyStimulus("DIVU 7/0", 3'd5, 64'd7, 64'd0, 5'd10, ONES, 1);
    applyStimulus("REMU 7/0", 3'd7, 64'd7, 64'd0, 5'd11, 64'd7, 1);
    applyStimulus("DIV min/-1", 3'd4, MIN, ONES, 5'd12, MIN, 1);
    applyStimulus("REM min/-1", 3'd6, MIN, ONES, 5'd13, 64'd0, 1);
    applyStimulus("REM -7,2", 3'd6, -64'sd7, 64'd2, 5'd14, ONES, 65);
    applyStimulus("DIV -7,2", 3'd4, -64'sd7, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    applyStimulus("MUL 7*6 b2b", 3'd0, 64'd7, 64'd6, 5'd16, 64'd42, 65);
    applyStimulus("DIV 7,-2", 3'd4, 64'd7, -64'sd2, 5'd17, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    applyStimulus("REM 7,-2", 3'd6, 64'd7, -64'sd2, 5'd18, 64'd1, 65);
    applyStimulus("DIVU 100/7", 3'd5, 64'd100, 64'd7, 5'd19, 64'd14, 65);
    applyStimulus("REMU 100/7", 3'd7, 64'd100, 64'd7, 5'd20, 64'd2, 65);
    idleCycles(2);

    driveOp(3'd0, 64'd9, 64'd9, 5'd3);
    repeat (10) @(posedge clk);
    #1;
    flush_EX = 1'b1;
    @(negedge clk);
    checkOutput("flush stall_EX", {63'b0, stall_EX}, 64'd0);
    @(posedge clk);
    #1;
    flush_EX = 1'b0; valid_EX = 1'b0;
    @(negedge clk);
    checkOutput("flush busy", {63'b0, busy}, 64'd0);
    checkOutput("flush result_valid", {63'b0, result_valid}, 64'd0);
    idleCycles(70);
    applyStimulus("MUL 2*2 after flush", 3'd0, 64'd2, 64'd2, 5'd4, 64'd4, 65);

    driveOp(3'd0, 64'd3, 64'd3, 5'd21);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset-low stall_EX", {63'b0, stall_EX}, 64'd0);
    checkOutput("reset-low busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    valid_EX = 1'b0;
    @(negedge clk);
    checkOutput("mid reset result", result, 64'd0);
    checkOutput("mid reset rd_out", {59'b0, rd_out}, 64'd0);
    checkOutput("mid reset result_valid", {63'b0, result_valid}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycles(2);

    @(posedge clk);
    #1;
    valid_EX = 1'b1; opcode_EX = OPC_OP; funct7_EX = 7'b0000000; funct3_EX = 3'd0;
    reg_data1_EX = 64'd1; reg_data2_EX = 64'd2; rd_EX = 5'd22;
    repeat (3) begin
      @(negedge clk);
      checkOutput("ADD stall_EX", {63'b0, stall_EX}, 64'd0);
      checkOutput("ADD busy", {63'b0, busy}, 64'd0);
    end
    idleCycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
